// File: rtl/memtest_pkg.sv
// Shared types and constants for the memory-test sequencer: state encoding,
// display tags and the PASS display code.
package memtest_pkg;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_WRITE    = 3'd1,
      ST_RD_ISSUE = 3'd2,
      ST_RD_CHECK = 3'd3,
      ST_PASS     = 3'd4,
      ST_FAIL     = 3'd5
   } state_e;

   localparam logic [3:0]  TAG_WR    = 4'h1;
   localparam logic [3:0]  TAG_RD    = 4'h2;
   localparam logic [3:0]  TAG_ERR   = 4'hE;
   localparam logic [15:0] PASS_CODE = 16'h600D;

   // Display word: tag nibble on seg3, 12-bit value on seg2..seg0.
   function automatic logic [15:0] disp_word(input logic [3:0] tag, input logic [11:0] val);
      return {tag, val};
   endfunction

endpackage

// File: rtl/memtest_sequencer_if.sv
// RAM-under-test bus: the sequencer is master, the RAM is slave.
interface memtest_sequencer_if #(
   parameter int unsigned ADDR_W = 10
);
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [15:0]       mem_wdata;
   logic [15:0]       mem_rdata;

   modport master (output mem_we, output mem_addr, output mem_wdata, input mem_rdata);
   modport slave  (input mem_we, input mem_addr, input mem_wdata, output mem_rdata);
endinterface

// File: rtl/memtest_sequencer_hold_timer.sv
// hold_timer: one-clock tick every HOLD_CYCLES clocks while en is high; the
// count is held at zero while disabled, so it restarts whenever en rises.
module hold_timer #(
   parameter int unsigned HOLD_CYCLES = 50000000
) (
   input  logic clk,
   input  logic rst,
   input  logic en,
   output logic tick
);

   localparam int unsigned CW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
   localparam logic [CW-1:0] LAST = CW'(HOLD_CYCLES - 1);

   logic [CW-1:0] cnt_q, cnt_d;

   always_comb begin
      tick  = 1'b0;
      cnt_d = cnt_q;
      if (!en) begin
         cnt_d = '0;
      end else if (cnt_q == LAST) begin
         tick  = 1'b1;
         cnt_d = '0;
      end else begin
         cnt_d = cnt_q + CW'(1);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) cnt_q <= '0;
      else      cnt_q <= cnt_d;
   end

endmodule

// File: rtl/memtest_sequencer.sv
// Memory-test sequencer: writes addr^SEED to every RAM word, reads it back and
// reports PASS/FAIL on a 16-bit display word. Optional MEMTEST_ERR_COUNT_EN
// keeps sweeping after mismatches and shows an error count in FAIL.
module memtest_sequencer
   import memtest_pkg::*;
#(
   parameter int unsigned ADDR_W      = 10,
   parameter int unsigned DATA_W      = 16,
   parameter logic [15:0] SEED        = 16'hA5C3,
   parameter int unsigned HOLD_CYCLES = 50000000
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                start,
   memtest_sequencer_if.master mem,
   output logic [15:0]         out,
   output logic                busy,
   output logic                pass,
   output logic                fail
);

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic              start_q;
   logic              mem_we_q, mem_we_d;
   logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
   logic [15:0]       mem_wdata_q, mem_wdata_d;
   logic [15:0]       out_q, out_d;
   logic              busy_q, busy_d;
   logic              pass_q, pass_d;
   logic              fail_q, fail_d;
   logic [ADDR_W-1:0] fail_addr_q, fail_addr_d;
   logic [DATA_W-1:0] fail_data_q, fail_data_d;
   logic              phase_q, phase_d;
`ifdef MEMTEST_ERR_COUNT_EN
   logic [15:0]       err_cnt_q, err_cnt_d;
`endif

   logic start_edge, last_addr, mismatch, hold_en, hold_tick;

   function automatic logic [DATA_W-1:0] pattern(input logic [ADDR_W-1:0] a);
      return DATA_W'(a) ^ SEED;
   endfunction

   assign hold_en = (state_q == ST_FAIL);

   hold_timer #(.HOLD_CYCLES(HOLD_CYCLES)) u_hold_timer (
      .clk  (clk),
      .rst  (rst),
      .en   (hold_en),
      .tick (hold_tick)
   );

   assign start_edge = start & ~start_q;
   assign last_addr  = (addr_q == '1);
   assign mismatch   = (mem.mem_rdata != pattern(addr_q));

   always_comb begin
      state_d     = state_q;
      addr_d      = addr_q;
      fail_addr_d = fail_addr_q;
      fail_data_d = fail_data_q;
      phase_d     = phase_q;
`ifdef MEMTEST_ERR_COUNT_EN
      err_cnt_d   = err_cnt_q;
`endif

      case (state_q)
         ST_IDLE, ST_PASS, ST_FAIL: begin
            if (start_edge) begin
               state_d = ST_WRITE;
               addr_d  = '0;
               phase_d = 1'b0;
`ifdef MEMTEST_ERR_COUNT_EN
               err_cnt_d = '0;
`endif
            end else if (state_q == ST_FAIL && hold_tick) begin
               phase_d = ~phase_q;
            end
         end
         ST_WRITE: begin
            if (last_addr) begin
               state_d = ST_RD_ISSUE;
               addr_d  = '0;
            end else begin
               addr_d  = addr_q + ADDR_W'(1);
            end
         end
         ST_RD_ISSUE: state_d = ST_RD_CHECK;
         ST_RD_CHECK: begin
`ifdef MEMTEST_ERR_COUNT_EN
            // Only the first error is captured; later ones just bump the count.
            if (mismatch) begin
               if (err_cnt_q == '0) begin
                  fail_addr_d = addr_q;
                  fail_data_d = mem.mem_rdata;
               end
               if (err_cnt_q != '1) err_cnt_d = err_cnt_q + 16'd1;
            end
            if (last_addr) begin
               state_d = (err_cnt_d != '0) ? ST_FAIL : ST_PASS;
               phase_d = 1'b0;
            end else begin
               state_d = ST_RD_ISSUE;
               addr_d  = addr_q + ADDR_W'(1);
            end
`else
            if (mismatch) begin
               fail_addr_d = addr_q;
               fail_data_d = mem.mem_rdata;
               state_d     = ST_FAIL;
               phase_d     = 1'b0;
            end else if (last_addr) begin
               state_d = ST_PASS;
            end else begin
               state_d = ST_RD_ISSUE;
               addr_d  = addr_q + ADDR_W'(1);
            end
`endif
         end
         default: state_d = ST_IDLE;
      endcase

      // Outputs are registered, so they are derived from the next state.
      mem_we_d    = 1'b0;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      out_d       = '0;
      busy_d      = 1'b0;
      pass_d      = 1'b0;
      fail_d      = 1'b0;

      case (state_d)
         ST_WRITE: begin
            mem_we_d    = 1'b1;
            mem_addr_d  = addr_d;
            mem_wdata_d = pattern(addr_d);
            out_d       = disp_word(TAG_WR, 12'(addr_d));
            busy_d      = 1'b1;
         end
         ST_RD_ISSUE, ST_RD_CHECK: begin
            mem_addr_d = addr_d;
            out_d      = disp_word(TAG_RD, 12'(addr_d));
            busy_d     = 1'b1;
         end
         ST_PASS: begin
            pass_d = 1'b1;
            out_d  = PASS_CODE;
         end
         ST_FAIL: begin
            fail_d = 1'b1;
`ifdef MEMTEST_ERR_COUNT_EN
            out_d  = phase_d ? err_cnt_d : disp_word(TAG_ERR, 12'(fail_addr_d));
`else
            out_d  = phase_d ? fail_data_d : disp_word(TAG_ERR, 12'(fail_addr_d));
`endif
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= ST_IDLE;
         addr_q      <= '0;
         start_q     <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         out_q       <= '0;
         busy_q      <= 1'b0;
         pass_q      <= 1'b0;
         fail_q      <= 1'b0;
         fail_addr_q <= '0;
         fail_data_q <= '0;
         phase_q     <= 1'b0;
`ifdef MEMTEST_ERR_COUNT_EN
         err_cnt_q   <= '0;
`endif
      end else begin
         state_q     <= state_d;
         addr_q      <= addr_d;
         start_q     <= start;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         out_q       <= out_d;
         busy_q      <= busy_d;
         pass_q      <= pass_d;
         fail_q      <= fail_d;
         fail_addr_q <= fail_addr_d;
         fail_data_q <= fail_data_d;
         phase_q     <= phase_d;
`ifdef MEMTEST_ERR_COUNT_EN
         err_cnt_q   <= err_cnt_d;
`endif
      end
   end

   assign mem.mem_we    = mem_we_q;
   assign mem.mem_addr  = mem_addr_q;
   assign mem.mem_wdata = mem_wdata_q;
   assign out           = out_q;
   assign busy          = busy_q;
   assign pass          = pass_q;
   assign fail          = fail_q;

endmodule
